// File: rtl/counter_slot_arbiter.sv
// Round-robin arbiter that lends one shared W-bit up-counter to N requesters for dur+1 cycles each.
// Optional completed-slot statistics counter enabled by defining SLOT_STATS_EN.
module counter_slot_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] dur_i,
  output logic [N-1:0]   grant_o,
  output logic           busy_o,
  output logic [W-1:0]   cnt_o,
  output logic [N-1:0]   done_o,
  output logic [7:0]     grant_count_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q,  done_d;
  logic [W-1:0]    cnt_q,   cnt_d;
  logic [W-1:0]    dur_q,   dur_d;
  logic [IW-1:0]   rr_q,    rr_d;
  logic [IW-1:0]   win_q,   win_d;

  logic            arb_hit;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   scan_idx;
  logic [W-1:0]    arb_dur;
  logic [IW-1:0]   win_nxt;

  // Scan downward in offset so the closest requester above rr_q is the last writer.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    scan_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      scan_idx = IW'((int'(rr_q) + k) % N);
      if (req_i[scan_idx]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx;
      end
    end
  end

  always_comb begin
    arb_dur = '0;
    for (int i = 0; i < N; i++)
      if (arb_idx == IW'(i)) arb_dur = dur_i[i*W +: W];
  end

  assign win_nxt = (win_q == IW'(N-1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    rr_d    = rr_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          win_d            = arb_idx;
          dur_d            = arb_dur;
          cnt_d            = '0;
          state_d          = RUN;
        end
      end
      RUN: begin
        // A dropped request aborts even on the final count.
        if (!req_i[win_q]) begin
          grant_d = '0;
          cnt_d   = '0;
          rr_d    = win_nxt;
          state_d = IDLE;
        end else if (cnt_q == dur_q) begin
          grant_d        = '0;
          done_d[win_q]  = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        rr_d    = win_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      dur_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign cnt_o   = cnt_q;
  assign busy_o  = (state_q != IDLE);

`ifdef SLOT_STATS_EN
  logic [7:0] gcnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gcnt_q <= '0;
    else if (state_q == RUN && state_d == DONE && gcnt_q != 8'hFF)
      gcnt_q <= gcnt_q + 8'd1;
  end
  assign grant_count_o = gcnt_q;
`else
  assign grant_count_o = '0;
`endif

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed-vector bench for counter_slot_arbiter (N=4, W=4), expected values computed by hand.
module tb_counter_slot_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] dur;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  cnt;
  logic [3:0]  done;
  logic [7:0]  grant_count;

  int nvec = 0;
  int nerr = 0;

  counter_slot_arbiter #(.N(4), .W(4)) dut (
    .clk(clk), .reset(reset), .req_i(req), .dur_i(dur),
    .grant_o(grant), .busy_o(busy), .cnt_o(cnt), .done_o(done),
    .grant_count_o(grant_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_gc(input int n);
`ifdef SLOT_STATS_EN
    return 8'(n);
`else
    return 8'(n * 0);
`endif
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  initial begin
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    tick();
    tick();
    reset = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant", 32'(grant), 0);
      chk("idle_busy",  32'(busy),  0);
      chk("idle_cnt",   32'(cnt),   0);
      chk("idle_done",  32'(done),  0);
    end
    chk("idle_gc", 32'(grant_count), 0);

    // Single slot, dur0=3
    req = 4'b0001;
    dur = 16'h0003;
    tick();
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_cnt0",  32'(cnt),   0);
    chk("s1_busy",  32'(busy),  1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("s1_cnt",    32'(cnt),   32'(i));
      chk("s1_grant_h", 32'(grant), 32'h1);
    end
    tick();
    chk("s1_done",      32'(done),  32'h1);
    chk("s1_grant_off", 32'(grant), 0);
    chk("s1_cnt_hold",  32'(cnt),   3);
    chk("s1_busy_done", 32'(busy),  1);
    chk("s1_gc",        32'(grant_count), 32'(exp_gc(1)));
    req = '0;
    tick();
    chk("s1_done_clr", 32'(done), 0);
    chk("s1_idle",     32'(busy), 0);
    chk("s1_cnt_clr",  32'(cnt),  0);

    // Round robin, all requesting with dur=0; reset first so rr starts at 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    dur = 16'h0000;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(oh(g % 4)));
      chk("rr_cnt",   32'(cnt),   0);
      tick();
      chk("rr_done",     32'(done),  32'(oh(g % 4)));
      chk("rr_grant_lo", 32'(grant), 0);
      tick();
      chk("rr_gap_grant", 32'(grant), 0);
      chk("rr_gap_busy",  32'(busy),  0);
    end
    req = '0;
    chk("rr_gc", 32'(grant_count), 32'(exp_gc(5)));

    // Max duration with mid-slot dur change; rr=1 so req0 wins via wrap
    req = 4'b0001;
    dur = 16'h000F;
    tick();
    chk("max_grant", 32'(grant), 32'h1);
    chk("max_cnt0",  32'(cnt),   0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("max_cnt",   32'(cnt),   32'(i));
      chk("max_grant", 32'(grant), 32'h1);
      if (i == 5) dur = 16'h0002;
    end
    tick();
    chk("max_done",  32'(done),  32'h1);
    chk("max_nowrap", 32'(cnt),  15);
    chk("max_grant_lo", 32'(grant), 0);
    chk("max_gc",    32'(grant_count), 32'(exp_gc(6)));
    req = '0;
    tick();

    // Abort req2 at cnt=3 with req3 pending
    dur = 16'h9700;
    req = 4'b1100;
    tick();
    chk("ab_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 3; i++) tick();
    chk("ab_cnt3", 32'(cnt), 3);
    req = 4'b1000;
    tick();
    chk("ab_grant_lo", 32'(grant), 0);
    chk("ab_cnt",      32'(cnt),   0);
    chk("ab_busy",     32'(busy),  0);
    chk("ab_nodone",   32'(done),  0);
    tick();
    chk("ab_next_grant", 32'(grant), 32'h8);
    chk("ab_next_cnt",   32'(cnt),   0);
    chk("ab_gc",         32'(grant_count), 32'(exp_gc(6)));

    // Async reset mid-slot, then pointer back at 0
    for (int i = 0; i < 5; i++) tick();
    chk("rst_pre_cnt", 32'(cnt), 5);
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_cnt",   32'(cnt),   0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_done",  32'(done),  0);
    chk("rst_gc",    32'(grant_count), 0);
    req = 4'b1010;
    dur = 16'h0010;
    tick();
    chk("rst_hold_grant", 32'(grant), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'h2);
    tick();
    chk("post_rst_cnt", 32'(cnt), 1);
    tick();
    chk("post_rst_done", 32'(done), 32'h2);
    req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/counter_slot_arbiter.md
Name: counter_slot_arbiter

Overview:
Round-robin arbiter and sequencer that shares one W-bit up-counter timing resource between N requesters. Each requester asks for a timed slot of a programmable length. The winner holds the counter for dur+1 cycles and then receives a one-cycle done pulse. The block sits between the requesting agents and the shared interval counter; it owns the counter, so no other logic drives it.

Parameters:
N, 4, number of requesters (2..8)
W, 4, counter/duration width in bits

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
req  input  N  level request per requester; must stay high until done or it aborts
dur  input  N*W  per-requester slot length; field i = dur[i*W +: W]
grant  output  N  one-hot grant, registered; all-zero when no slot active
busy  output  1  high in RUN or DONE
cnt  output  W  current shared counter value
done  output  N  one-hot, one-cycle pulse at normal slot completion
grant_count  output  8  completed-slot count (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, grant=0, busy=0, cnt=0, done=0, rr pointer=0, grant_count=0.
- States:
  - IDLE: arbitrates.
  - RUN: grant asserted, counter running.
  - DONE: done pulse, grant low.
- IDLE:
  - If req!=0, select the first set bit scanning upward from rr pointer, with modulo-N wrap.
  - At the next edge: grant <= onehot(winner), latch dur_l <= dur field of winner, cnt <= 0, state -> RUN.
  - Latency req->grant = 1 cycle.
  - If req==0, remain in IDLE; outputs stay at reset values.
- RUN, every edge:
  - If req[winner]==0: abort. grant<=0, cnt<=0, state -> IDLE, no done pulse, rr pointer <= winner+1 mod N.
  - Else if cnt==dur_l: grant<=0, done[winner]<=1, state -> DONE.
  - Else cnt<=cnt+1.
- Slot length: grant is high for exactly dur_l+1 cycles (cnt shows 0..dur_l).
  - dur=0 gives a 1-cycle grant.
  - dur=2^W-1 gives 2^W cycles.
  - cnt never wraps; it stops at dur_l.
- DONE (single cycle):
  - done pulse visible; cnt holds dur_l.
  - Next edge: done<=0, cnt<=0, rr pointer <= winner+1 mod N, state -> IDLE.
- Turnaround: new grant earliest 2 cycles after done rises (DONE -> IDLE -> grant).
- Simultaneous requests resolve purely by rr pointer; no fixed priority.
- Requests from non-winners during RUN/DONE are held pending, not latched; a requester that drops req before IDLE arbitration is not served.
- dur changes after grant are ignored (dur_l latched).
- Abort and completion in the same cycle (req[winner] low while cnt==dur_l): abort wins, no done.
- Reset asserted mid-slot: immediate return to reset values, no done pulse, rr pointer=0.
- busy = (state != IDLE), registered-equivalent (derived from state register).

Optional Feature:
Macro SLOT_STATS_EN.
- Defined:
  - grant_count increments by 1 in the cycle done pulses (DONE entry).
  - Saturates at 255; aborted slots do not count.
  - Cleared only by reset.
- Not defined:
  - No counter logic is built; grant_count tied to 0.
  - Port list unchanged.

Test Plan:
- Reset, req=0 for 5 cycles -> grant=0, busy=0, cnt=0, done=0 throughout.
- req=4'b0001, dur0=3 -> grant=0001 one cycle after req, cnt 0,1,2,3 over 4 cycles, done=0001 for 1 cycle, grant drops same cycle; SLOT_STATS_EN: grant_count=1.
- req=4'b1111 held, all dur=0 -> grants in order 0001,0010,0100,1000,0001, each 1 cycle, 2-cycle gap between grants, done pulses in same order.
- req0 granted with dur0=15 -> 16 grant cycles, cnt reaches 15, no wrap to 0 while granted; dur0 changed to 2 mid-slot -> still 16 cycles.
- req2 granted with dur2=7; drop req2 at cnt=3 -> grant 0 next edge, no done, state IDLE, pending req3 granted next; grant_count unchanged.
- Assert reset at cnt=5 of an active slot -> grant, cnt, done, busy 0 immediately; after release, req=1010 -> bit1 granted first (pointer reset to 0).
